// File: rtl/uart_rx_ctrl.sv
// UART receive controller: acks bytes from a UART receiver into a small FIFO
// and holds the receiver's baud/parity configuration registers.
module uart_rx_ctrl #(
   parameter int          FIFO_DEPTH     = 4,
   parameter logic [15:0] DIVIDER_RESET  = 16'd2,
   parameter bit          DROP_WHEN_FULL = 1'b0,
   localparam int         AW = $clog2(FIFO_DEPTH),
   localparam int         CW = AW + 1
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic [7:0]    rx_data_i,
   input  logic          rx_ready_i,
   output logic          rx_ack_o,
   output logic [15:0]   clock_divider_o,
   output logic          parity_bit_o,
   output logic          parity_even_o,
   input  logic          cfg_we_i,
   input  logic [15:0]   cfg_divider_i,
   input  logic          cfg_parity_bit_i,
   input  logic          cfg_parity_even_i,
   output logic [7:0]    out_data_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [CW-1:0] fifo_count_o,
   output logic [7:0]    drop_count_o
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t        r_state;
   logic          r_ack;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_drop;
   logic [15:0]   r_div;
   logic          r_par;
   logic          r_even;

   logic w_full;
   logic w_empty;
   logic w_offer;
   logic w_push;
   logic w_drop;
   logic w_pop;

   // Full is judged on the pre-edge count, so a same-cycle pop never frees room
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_offer = (r_state == S_WAIT) && rx_ready_i;
   assign w_push  = w_offer && !w_full;
   assign w_drop  = w_offer && w_full && DROP_WHEN_FULL;
   assign w_pop   = out_ready_i && !w_empty;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= S_WAIT;
         r_ack   <= 1'b0;
      end else begin
         unique case (r_state)
            S_WAIT: begin
               if (w_push || w_drop) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end
            end
            S_ACK: begin
               r_state <= S_RELEASE;
               r_ack   <= 1'b0;
            end
            S_RELEASE: begin
               r_state <= S_WAIT;
               r_ack   <= 1'b0;
            end
            default: begin
               r_state <= S_WAIT;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the count
   always_ff @(posedge clock_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= rx_data_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_drop <= '0;
      end else if (w_drop && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

   // A zero divider would stall the receiver, so it is stored as one
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_div  <= DIVIDER_RESET;
         r_par  <= 1'b0;
         r_even <= 1'b0;
      end else if (cfg_we_i) begin
         r_div  <= (cfg_divider_i == 16'd0) ? 16'd1 : cfg_divider_i;
         r_par  <= cfg_parity_bit_i;
         r_even <= cfg_parity_even_i;
      end
   end

   assign rx_ack_o        = r_ack;
   assign clock_divider_o = r_div;
   assign parity_bit_o    = r_par;
   assign parity_even_o   = r_even;
   assign out_data_o      = r_mem[r_rptr];
   assign out_valid_o     = !w_empty;
   assign fifo_count_o    = r_count;
   assign drop_count_o    = r_drop;

endmodule
